frame_buffer_arbiter: RTL

- Ping-pong controller for a two-bank frame buffer BRAM.
- The write side comes from the pixel-capture stream (per-pixel we/addr/data). The read side is the pattern-recognition engine, which claims one complete frame at a time.
- Tracks the state of each bank and steers writes to the filling bank.
- Hands the most recent complete frame to the reader, dropping frames when the reader is too slow.

---
 rtl/frame_buffer_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buffer_arbiter
//
// Ping-pong controller for a two-bank frame buffer BRAM. The pixel-capture
// stream writes into whichever bank is currently FILLING. The recognition
// engine claims one complete frame at a time. The newest complete frame is
// always the one offered to the reader, and older unread frames are dropped
// when the reader falls behind.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   wr_we_in        : capture pixel write strobe
//   wr_addr_in      : capture pixel address (y*IMG_WIDTH + x)
//   wr_data_in      : capture pixel data
//   rd_req          : reader wants a frame (level, held until rd_grant)
//   rd_done         : reader finished with its granted frame (1-cycle pulse)
//   rd_addr_in      : reader pixel address within the granted frame
//   rd_grant        : reader owns rd_bank
//   rd_bank         : bank granted to the reader (holds after release)
//   rd_frame_seq    : sequence tag of the granted frame (holds after release)
//   frame_ready     : a complete unread frame is waiting
//   mem_we/mem_waddr/mem_wdata : registered BRAM write port, {bank, addr}
//   mem_raddr       : combinational BRAM read address, {rd_bank, rd_addr_in}
//   drop_count      : saturating count of discarded frames
// -----------------------------------------------------------------------------
module frame_buffer_arbiter #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int W          = 8,
    localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT,
    localparam int ADDR_W    = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_we_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [W-1:0]      wr_data_in,
    input  logic              rd_req,
    input  logic              rd_done,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_grant,
    output logic              rd_bank,
    output logic [15:0]       rd_frame_seq,
    output logic              frame_ready,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [W-1:0]      mem_wdata,
    output logic [ADDR_W:0]   mem_raddr,
    output logic [15:0]       drop_count
);

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic [15:0] tag_q  [2];
    logic [15:0] tag_d  [2];

    logic        wr_bank_q, wr_bank_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] drop_q, drop_d;
    logic        grant_q, grant_d;
    logic        rd_bank_q, rd_bank_d;
    logic [15:0] rd_seq_q, rd_seq_d;
    logic        frame_ready_q;

    logic              mem_we_q;
    logic [ADDR_W:0]   mem_waddr_q;
    logic [W-1:0]      mem_wdata_q;

    logic [1:0] ready_now;   // READY flags at the start of the cycle
    logic [1:0] ready_next;  // READY flags after this cycle's updates
    logic       eof;
    logic       other_bank;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_now[gi]  = (bank_q[gi] == BANK_READY);
        assign ready_next[gi] = (bank_d[gi] == BANK_READY);
    end

    // Out-of-range addresses never match LAST_PIX, so they are forwarded
    // to memory without ending the frame.
    assign eof        = wr_we_in && (wr_addr_in == LAST_PIX);
    assign other_bank = ~wr_bank_q;

    always_comb begin
        bank_d    = bank_q;
        tag_d     = tag_q;
        wr_bank_d = wr_bank_q;
        seq_d     = seq_q;
        drop_d    = drop_q;
        grant_d   = grant_q;
        rd_bank_d = rd_bank_q;
        rd_seq_d  = rd_seq_q;

        // Release first, so an EOF in the same cycle sees the bank as FREE.
        if (grant_q && rd_done) begin
            bank_d[rd_bank_q] = BANK_FREE;
            grant_d           = 1'b0;
        end

        // Claim uses start-of-cycle READY flags. At most one bank can be
        // READY because the other is always FILLING, so bit 1 names it.
        // The claim is applied before EOF so a simultaneous EOF finds the
        // bank READING and never overwrites what the reader just took.
        if (!grant_q && rd_req && (|ready_now)) begin
            grant_d                = 1'b1;
            rd_bank_d              = ready_now[1];
            rd_seq_d               = tag_q[ready_now[1]];
            bank_d[ready_now[1]]   = BANK_READING;
        end

        if (eof) begin
            seq_d = seq_q + 16'd1;
            if (bank_d[other_bank] == BANK_READING) begin
                // Nowhere to go: keep filling the same bank, frame is lost.
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end else begin
                // An unread older frame in the other bank gets replaced.
                if (bank_d[other_bank] == BANK_READY && drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
                bank_d[wr_bank_q]  = BANK_READY;
                tag_d[wr_bank_q]   = seq_q;
                bank_d[other_bank] = BANK_FILLING;
                wr_bank_d          = other_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                bank_q[i] <= (i == 0) ? BANK_FILLING : BANK_FREE;
                tag_q[i]  <= '0;
            end
            wr_bank_q     <= 1'b0;
            seq_q         <= '0;
            drop_q        <= '0;
            grant_q       <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_seq_q      <= '0;
            frame_ready_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bank_q[i] <= bank_d[i];
                tag_q[i]  <= tag_d[i];
            end
            wr_bank_q     <= wr_bank_d;
            seq_q         <= seq_d;
            drop_q        <= drop_d;
            grant_q       <= grant_d;
            rd_bank_q     <= rd_bank_d;
            rd_seq_q      <= rd_seq_d;
            frame_ready_q <= |ready_next;
            // Bank is sampled alongside the strobe, so the EOF pixel lands
            // in the bank that was filling.
            mem_we_q      <= wr_we_in;
            mem_waddr_q   <= {wr_bank_q, wr_addr_in};
            mem_wdata_q   <= wr_data_in;
        end
    end

    assign rd_grant     = grant_q;
    assign rd_bank      = rd_bank_q;
    assign rd_frame_seq = rd_seq_q;
    assign frame_ready  = frame_ready_q;
    assign drop_count   = drop_q;
    assign mem_we       = mem_we_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_raddr    = {rd_bank_q, rd_addr_in};

endmodule
